// File: rtl/clk_rst_seq.sv
// Reset sequencer behind the board PLL: waits for a stable lock, releases reset
// domains in ascending order, and strobes the fractional-rate tick once running.
module clk_rst_seq #(
  parameter int NUM_DOMAINS        = 3,
  parameter int LOCK_STABLE_CYCLES = 1024,
  parameter int RELEASE_GAP        = 16,
  parameter int DEBOUNCE_CYCLES    = 65536,
  parameter int CLK_FRAC_RATE      = 5,
  parameter int SYNC_STAGES        = 2
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   pll_lock_i,
  input  logic                   btn_ni,
  output logic [NUM_DOMAINS-1:0] rst_o,
  output logic                   ready_o,
  output logic                   tick_o,
  output logic [1:0]             state_o
);
  localparam int ST_W   = (LOCK_STABLE_CYCLES > 1) ? $clog2(LOCK_STABLE_CYCLES) : 1;
  localparam int GAP_W  = (RELEASE_GAP > 1) ? $clog2(RELEASE_GAP) : 1;
  localparam int CNT_W  = (ST_W > GAP_W) ? ST_W : GAP_W;
  localparam int IDX_W  = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;
  // The debounce counter has to hold its saturation value itself.
  localparam int DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int TICK_W = (CLK_FRAC_RATE > 1) ? $clog2(CLK_FRAC_RATE) : 1;

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    STABLE    = 2'd1,
    RELEASE   = 2'd2,
    RUN       = 2'd3
  } state_t;

  logic [SYNC_STAGES-1:0] lock_sync;
  logic [SYNC_STAGES-1:0] btn_sync;
  logic [DB_W-1:0]        db_cnt;
  logic [CNT_W-1:0]       cnt;
  logic [IDX_W-1:0]       idx;
  logic [TICK_W-1:0]      tick_cnt;
  state_t                 state;
  logic                   lock_s;
  logic                   btn_s;
  logic                   pressed;
  logic                   fault;

  assign lock_s  = lock_sync[SYNC_STAGES-1];
  assign btn_s   = btn_sync[SYNC_STAGES-1];
  assign pressed = (db_cnt == DB_W'(DEBOUNCE_CYCLES));
  assign fault   = !lock_s || pressed;
  assign state_o = state;

  // Button chain resets to the idle (high) level so reset never looks like a press.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      lock_sync <= '0;
      btn_sync  <= '1;
      db_cnt    <= '0;
    end else begin
      lock_sync <= {lock_sync[SYNC_STAGES-2:0], pll_lock_i};
      btn_sync  <= {btn_sync[SYNC_STAGES-2:0], btn_ni};
      if (btn_s)
        db_cnt <= '0;
      else if (!pressed)
        db_cnt <= db_cnt + DB_W'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state    <= WAIT_LOCK;
      cnt      <= '0;
      idx      <= '0;
      tick_cnt <= '0;
      rst_o    <= '1;
      ready_o  <= 1'b0;
      tick_o   <= 1'b0;
    end else if (fault) begin
      state    <= WAIT_LOCK;
      cnt      <= '0;
      idx      <= '0;
      tick_cnt <= '0;
      rst_o    <= '1;
      ready_o  <= 1'b0;
      tick_o   <= 1'b0;
    end else begin
      case (state)
        WAIT_LOCK: begin
          state <= STABLE;
          cnt   <= '0;
          idx   <= '0;
        end
        STABLE: begin
          if (cnt == CNT_W'(LOCK_STABLE_CYCLES - 1)) begin
            state <= RELEASE;
            cnt   <= '0;
            idx   <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        RELEASE: begin
          if (cnt == CNT_W'(RELEASE_GAP - 1)) begin
            // Domains release bottom-up, so shifting keeps the ones-above-zeros shape.
            rst_o <= rst_o << 1;
            cnt   <= '0;
            if (idx == IDX_W'(NUM_DOMAINS - 1)) begin
              state    <= RUN;
              ready_o  <= 1'b1;
              tick_cnt <= '0;
              tick_o   <= (CLK_FRAC_RATE == 1);
            end else begin
              idx <= idx + IDX_W'(1);
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        RUN: begin
          if (tick_cnt == TICK_W'(CLK_FRAC_RATE - 1)) begin
            tick_cnt <= '0;
            tick_o   <= 1'b1;
          end else begin
            tick_cnt <= tick_cnt + TICK_W'(1);
            tick_o   <= 1'b0;
          end
        end
        default: state <= WAIT_LOCK;
      endcase
    end
  end
endmodule

// File: tb/tb_clk_rst_seq.sv
// Bench for clk_rst_seq: a timing-rule reference model feeds a scoreboard that is
// checked every cycle for a RATE=5 and a RATE=1 instance sharing the same inputs.
module tb_clk_rst_seq;
  localparam int ND   = 3;
  localparam int LOCK = 8;
  localparam int GAP  = 4;
  localparam int DB   = 4;
  localparam int RATE = 5;
  localparam int SYNC = 2;

  typedef struct {
    logic [ND-1:0] rst;
    logic          ready;
    logic          tick;
    logic          tick1;
    logic [1:0]    state;
  } exp_t;

  logic          clk_i = 1'b0;
  logic          clk_en = 1'b1;
  logic          rst_i;
  logic          pll_lock_i;
  logic          btn_ni;
  logic [ND-1:0] rst_o, rst1_o;
  logic          ready_o, ready1_o, tick_o, tick1_o;
  logic [1:0]    state_o, state1_o;

  clk_rst_seq #(.NUM_DOMAINS(ND), .LOCK_STABLE_CYCLES(LOCK), .RELEASE_GAP(GAP),
    .DEBOUNCE_CYCLES(DB), .CLK_FRAC_RATE(RATE), .SYNC_STAGES(SYNC)) u_dut (
    .clk_i(clk_i), .rst_i(rst_i), .pll_lock_i(pll_lock_i), .btn_ni(btn_ni),
    .rst_o(rst_o), .ready_o(ready_o), .tick_o(tick_o), .state_o(state_o));

  clk_rst_seq #(.NUM_DOMAINS(ND), .LOCK_STABLE_CYCLES(LOCK), .RELEASE_GAP(GAP),
    .DEBOUNCE_CYCLES(DB), .CLK_FRAC_RATE(1), .SYNC_STAGES(SYNC)) u_dut1 (
    .clk_i(clk_i), .rst_i(rst_i), .pll_lock_i(pll_lock_i), .btn_ni(btn_ni),
    .rst_o(rst1_o), .ready_o(ready1_o), .tick_o(tick1_o), .state_o(state1_o));

  always begin
    #5;
    if (clk_en) clk_i = ~clk_i;
  end

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: outputs follow from how long the fault condition has been
  // continuously clear, using the documented timing rules.
  int   lockq[$];
  int   btnq[$];
  int   zrun, frun;
  bit   fault_q;
  exp_t sbq[$];

  function automatic exp_t predict(input int fr);
    exp_t e;
    int t, t_run;
    e.rst = '1; e.ready = 1'b0; e.tick = 1'b0; e.tick1 = 1'b0; e.state = 2'd0;
    t_run = LOCK + ND * GAP;
    if (fr > 0) begin
      t = fr - 1;
      if (t < LOCK) e.state = 2'd1;
      else if (t < t_run) begin
        e.state = 2'd2;
        e.rst = e.rst << ((t - LOCK) / GAP);
      end else begin
        e.state = 2'd3;
        e.rst   = '0;
        e.ready = 1'b1;
        e.tick  = (t > t_run) && ((t - t_run) % RATE == 0);
        e.tick1 = 1'b1;
      end
    end
    return e;
  endfunction

  always @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      lockq.delete(); btnq.delete(); sbq.delete();
      for (int i = 0; i < SYNC; i++) begin lockq.push_back(0); btnq.push_back(1); end
      zrun = 0; frun = 0; fault_q = 1'b1;
    end else begin
      if (fault_q) frun = 0; else frun++;
      if (btnq[SYNC-1] == 0) zrun++; else zrun = 0;
      lockq.push_front(int'(pll_lock_i)); void'(lockq.pop_back());
      btnq.push_front(int'(btn_ni));      void'(btnq.pop_back());
      fault_q = (lockq[SYNC-1] == 0) || (zrun >= DB);
      sbq.push_back(predict(frun));
    end
  end

  exp_t mon_e;
  always @(negedge clk_i) begin
    if (!rst_i && sbq.size() > 0) begin
      mon_e = sbq.pop_front();
      chk("sb_dut",  {rst_o, ready_o, tick_o, state_o},
                     {mon_e.rst, mon_e.ready, mon_e.tick, mon_e.state});
      chk("sb_dut1", {rst1_o, ready1_o, tick1_o, state1_o},
                     {mon_e.rst, mon_e.ready, mon_e.tick1, mon_e.state});
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk_i);
  endtask

  // Counts rising edges until rst_o shows pat; -1 if the budget runs out.
  task automatic wait_rst(input logic [ND-1:0] pat, input int budget, inout int n);
    int lim;
    lim = n + budget;
    while (n < lim) begin
      @(posedge clk_i); n++; #1;
      if (rst_o == pat) return;
    end
    n = -1;
  endtask

  task automatic wait_tick(input int budget, inout int n);
    int lim;
    lim = n + budget;
    while (n < lim) begin
      @(posedge clk_i); n++; #1;
      if (tick_o) return;
    end
    n = -1;
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n, k;
    rst_i = 1'b1; pll_lock_i = 1'b0; btn_ni = 1'b1;
    cyc(3);
    chk("reset_state", {rst_o, ready_o, tick_o, state_o}, {3'b111, 1'b0, 1'b0, 2'd0});
    rst_i = 1'b0;
    cyc(5);

    // Nominal release sequence
    pll_lock_i = 1'b1;
    n = 0; wait_rst(3'b110, 40, n); chk("nom_rel0", n, 15);
    wait_rst(3'b100, 40, n);        chk("nom_rel1", n, 19);
    wait_rst(3'b000, 40, n);        chk("nom_rel2", n, 23);
    chk("nom_ready", {ready_o, tick_o, tick1_o, state_o}, {1'b1, 1'b0, 1'b1, 2'd3});
    wait_tick(20, n);               chk("nom_tick1", n, 28);
    n = 0; wait_tick(20, n);        chk("nom_tick2", n, 5);
    cyc(10);

    // Lock loss while running, then recovery
    pll_lock_i = 1'b0;
    n = 0; wait_rst(3'b111, 10, n);
    chk("lockloss_lat", (n >= 1) && (n <= SYNC + 1), 1);
    cyc(4);
    pll_lock_i = 1'b1;
    n = 0; wait_rst(3'b110, 40, n); chk("relock_rel0", n, 15);
    wait_rst(3'b000, 40, n);

    // Lock glitch during the stable count
    @(negedge clk_i); pll_lock_i = 1'b0;
    cyc(5);
    pll_lock_i = 1'b1;
    cyc(8);
    pll_lock_i = 1'b0;
    cyc(3);
    chk("glitch_wait", {state_o, rst_o}, {2'd0, 3'b111});
    pll_lock_i = 1'b1;
    n = 0; wait_rst(3'b110, 40, n); chk("glitch_rel0", n, 15);
    wait_rst(3'b000, 40, n);

    // Button: short press ignored, long press resets, release restarts
    cyc(2);
    btn_ni = 1'b0; cyc(3); btn_ni = 1'b1;
    cyc(20);
    chk("btn_short", {ready_o, state_o, rst_o}, {1'b1, 2'd3, 3'b000});
    btn_ni = 1'b0;
    n = 0; wait_rst(3'b111, 20, n); chk("btn_long_lat", n, SYNC + DB + 1);
    cyc(2);
    btn_ni = 1'b1;
    n = 0; wait_rst(3'b000, 60, n); chk("btn_restart", n, 24);

    // Asynchronous reset mid-release with the clock stopped
    @(negedge clk_i); pll_lock_i = 1'b0;
    cyc(4);
    pll_lock_i = 1'b1;
    n = 0; wait_rst(3'b110, 40, n); chk("async_pre", n, 15);
    @(negedge clk_i);
    clk_en = 1'b0;
    #2 rst_i = 1'b1;
    #1;
    chk("async_rst",  {rst_o, ready_o, tick_o, state_o},     {3'b111, 1'b0, 1'b0, 2'd0});
    chk("async_rst1", {rst1_o, ready1_o, tick1_o, state1_o}, {3'b111, 1'b0, 1'b0, 2'd0});
    #3 rst_i = 1'b0;
    #4 clk_en = 1'b1;
    cyc(40);

    // Randomized lock drops, button presses and reset pulses
    for (int s = 0; s < 120; s++) begin
      k = $urandom_range(0, 9);
      @(negedge clk_i);
      if (k < 2) begin
        pll_lock_i = 1'b0; cyc($urandom_range(1, 4)); pll_lock_i = 1'b1;
      end else if (k < 4) begin
        btn_ni = 1'b0; cyc($urandom_range(1, 8)); btn_ni = 1'b1;
      end else if (k == 4) begin
        #2 rst_i = 1'b1;
        #2 rst_i = 1'b0;
      end
      cyc($urandom_range(1, 40));
    end
    cyc(5);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
